fu_complete_arbiter: RTL and testbench

Parametrised completion stage between the functional units and the CDB/PRF write ports. Each of NUM_FU units deposits finished results into its own small FIFO. An arbiter then drains up to CDB_WIDTH results per cycle, in either fixed-priority or round-robin order. Per-unit backpressure replaces the single global stall. Flush squashes all buffered results.

---
 rtl/fu_complete_arbiter_pkg.sv | 23 ++
 rtl/fu_complete_arbiter_if.sv | 31 +++
 rtl/fu_complete_arbiter_result_fifo.sv | 72 +++++++
 rtl/fu_complete_arbiter.sv | 94 +++++++++
 tb/tb_fu_complete_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_complete_arbiter_pkg.sv
// Shared types and defaults for the functional-unit completion stage.
// FU_COMPLETE_PACKET matches the result layout used by the rest of the core.
package fu_complete_arbiter_pkg;

    localparam int NUM_FU_DEFAULT    = 6;
    localparam int BUF_DEPTH_DEFAULT = 2;
    localparam int CDB_WIDTH_DEFAULT = 1;
    localparam bit RR_MODE_DEFAULT   = 1'b1;

    typedef logic [$clog2(NUM_FU_DEFAULT)-1:0] FU_IDX;

    typedef struct packed {
        logic [31:0] dest_value;
        logic [5:0]  dest_prn;
        logic [4:0]  rob_idx;
    } FU_COMPLETE_PACKET;

    // Increment with explicit wrap so non-power-of-two moduli behave.
    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/fu_complete_arbiter_if.sv
// Result-in / completion-out bundle between the functional units and the CDB.
interface fu_complete_arbiter_if
    import fu_complete_arbiter_pkg::*;
#(
    parameter int NUM_FU    = NUM_FU_DEFAULT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT,
    parameter int CDB_WIDTH = CDB_WIDTH_DEFAULT
);
    localparam int IDX_W = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [NUM_FU-1:0]                 fu_valid;
    FU_COMPLETE_PACKET [NUM_FU-1:0]    fu_packet;
    logic [NUM_FU-1:0]                 fu_ready;
    logic                              complete_ready;
    logic [CDB_WIDTH-1:0]              complete_valid;
    FU_COMPLETE_PACKET [CDB_WIDTH-1:0] complete_packet;
    logic [CDB_WIDTH-1:0][IDX_W-1:0]   complete_fu_idx;
    logic [NUM_FU-1:0][CNT_W-1:0]      buf_count;

    modport master (
        output fu_valid, fu_packet, complete_ready,
        input  fu_ready, complete_valid, complete_packet, complete_fu_idx, buf_count
    );

    modport slave (
        input  fu_valid, fu_packet, complete_ready,
        output fu_ready, complete_valid, complete_packet, complete_fu_idx, buf_count
    );

endinterface

// File: rtl/fu_complete_arbiter_result_fifo.sv
// Per-channel result FIFO: pushes beyond capacity are dropped, flush empties it.
module fu_result_fifo
    import fu_complete_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               push,
    input  FU_COMPLETE_PACKET                  push_data,
    input  logic                               pop,
    input  logic                               flush,
    output FU_COMPLETE_PACKET                  head_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     count,
    output logic                               not_full
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    FU_COMPLETE_PACKET mem_q [BUF_DEPTH];
    FU_COMPLETE_PACKET mem_d [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_en, pop_en;

    assign not_full  = (count_q < CNT_W'(BUF_DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets its default first so no path leaves a latch behind.
    always_comb begin
        push_en  = push && not_full;
        pop_en   = pop && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = PTR_W'(wrap_inc(int'(wr_ptr_q), BUF_DEPTH));
            end
            if (pop_en) begin
                rd_ptr_d = PTR_W'(wrap_inc(int'(rd_ptr_q), BUF_DEPTH));
            end
            count_d = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy gates every use of head_data.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fu_complete_arbiter.sv
// Completion stage: per-unit result FIFOs drained onto CDB_WIDTH grant slots
// in round-robin or fixed (highest index first) order.
module fu_complete_arbiter
    import fu_complete_arbiter_pkg::*;
#(
    parameter int NUM_FU    = NUM_FU_DEFAULT,
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT,
    parameter int CDB_WIDTH = CDB_WIDTH_DEFAULT,
    parameter bit RR_MODE   = RR_MODE_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    fu_complete_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    FU_COMPLETE_PACKET [NUM_FU-1:0]    head;
    logic [NUM_FU-1:0][CNT_W-1:0]      count;
    logic [NUM_FU-1:0]                 not_full;
    logic [NUM_FU-1:0]                 grant;
    logic [NUM_FU-1:0]                 pop;
    logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d, last_idx;
    logic [CDB_WIDTH-1:0]              slot_valid;
    logic [CDB_WIDTH-1:0][IDX_W-1:0]   slot_idx;
    FU_COMPLETE_PACKET [CDB_WIDTH-1:0] slot_pkt;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
        fu_result_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (bus.fu_valid[i] && !flush),
            .push_data (bus.fu_packet[i]),
            .pop       (pop[i]),
            .flush     (flush),
            .head_data (head[i]),
            .count     (count[i]),
            .not_full  (not_full[i])
        );
    end

    // Scan channels in priority order and fill slots with the first non-empty ones.
    always_comb begin
        int ch;
        int n;
        grant      = '0;
        slot_valid = '0;
        slot_idx   = '0;
        slot_pkt   = '0;
        last_idx   = rr_ptr_q;
        n          = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            ch = RR_MODE ? (int'(rr_ptr_q) + k) % NUM_FU : NUM_FU - 1 - k;
            if (count[ch] != '0 && n < CDB_WIDTH) begin
                slot_valid[n] = 1'b1;
                slot_idx[n]   = IDX_W'(ch);
                slot_pkt[n]   = head[ch];
                grant[ch]     = 1'b1;
                last_idx      = IDX_W'(ch);
                n             = n + 1;
            end
        end
    end

    assign pop = bus.complete_ready ? grant : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!flush && bus.complete_ready && (|grant)) begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(last_idx), NUM_FU));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.fu_ready        = not_full;
    assign bus.buf_count       = count;
    assign bus.complete_valid  = slot_valid;
    assign bus.complete_packet = slot_pkt;
    assign bus.complete_fu_idx = slot_idx;

    // A unit presenting to a full channel loses that result.
    a_no_push_when_full: assert property (
        @(posedge clock) disable iff (!reset) (bus.fu_valid & ~not_full) == '0
    );

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Bench: a round-robin single-slot instance and a fixed-priority dual-slot instance
// run side by side against a queue-based model of the completion stage.
module tb_fu_complete_arbiter;
    import fu_complete_arbiter_pkg::*;

    localparam int N     = 6;
    localparam int D     = 2;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(D + 1);

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    always #5 clock = ~clock;

    logic [N-1:0]      in_valid [2];
    FU_COMPLETE_PACKET in_pkt   [2][N];
    logic              in_cr    [2];

    logic [1:0]                   act_valid [2];
    logic [IDX_W-1:0]             act_idx   [2][2];
    FU_COMPLETE_PACKET            act_pkt   [2][2];
    logic [N-1:0]                 act_ready [2];
    logic [N-1:0][CNT_W-1:0]      act_cnt   [2];

    fu_complete_arbiter_if #(.NUM_FU(N), .BUF_DEPTH(D), .CDB_WIDTH(1)) if_a ();
    fu_complete_arbiter_if #(.NUM_FU(N), .BUF_DEPTH(D), .CDB_WIDTH(2)) if_b ();

    fu_complete_arbiter #(.NUM_FU(N), .BUF_DEPTH(D), .CDB_WIDTH(1), .RR_MODE(1'b1)) u_rr (
        .clock (clock), .reset (reset), .flush (flush), .bus (if_a.slave)
    );
    fu_complete_arbiter #(.NUM_FU(N), .BUF_DEPTH(D), .CDB_WIDTH(2), .RR_MODE(1'b0)) u_fx (
        .clock (clock), .reset (reset), .flush (flush), .bus (if_b.slave)
    );

    assign if_a.fu_valid       = in_valid[0];
    assign if_b.fu_valid       = in_valid[1];
    assign if_a.complete_ready = in_cr[0];
    assign if_b.complete_ready = in_cr[1];
    for (genvar i = 0; i < N; i++) begin : g_drv
        assign if_a.fu_packet[i] = in_pkt[0][i];
        assign if_b.fu_packet[i] = in_pkt[1][i];
    end

    assign act_valid[0]  = {1'b0, if_a.complete_valid};
    assign act_idx[0][0] = if_a.complete_fu_idx[0];
    assign act_idx[0][1] = '0;
    assign act_pkt[0][0] = if_a.complete_packet[0];
    assign act_pkt[0][1] = '0;
    assign act_ready[0]  = if_a.fu_ready;
    assign act_cnt[0]    = if_a.buf_count;
    assign act_valid[1]  = if_b.complete_valid;
    assign act_idx[1][0] = if_b.complete_fu_idx[0];
    assign act_idx[1][1] = if_b.complete_fu_idx[1];
    assign act_pkt[1][0] = if_b.complete_packet[0];
    assign act_pkt[1][1] = if_b.complete_packet[1];
    assign act_ready[1]  = if_b.fu_ready;
    assign act_cnt[1]    = if_b.buf_count;

    // Reference model: one queue per channel, plus the round-robin start point.
    FU_COMPLETE_PACKET mq [2][N][$];
    int mptr  [2] = '{0, 0};
    int cdbw  [2] = '{1, 2};
    bit rrm   [2] = '{1'b1, 1'b0};

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic FU_COMPLETE_PACKET rand_pkt();
        FU_COMPLETE_PACKET p;
        p.dest_value = $urandom;
        p.dest_prn   = 6'($urandom);
        p.rob_idx    = 5'($urandom);
        return p;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < N; ch++) mq[d][ch].delete();
            mptr[d] = 0;
        end
    endtask

    task automatic model_grants(input int d, output int n, output int sel [2]);
        int order [$];
        n      = 0;
        sel[0] = 0;
        sel[1] = 0;
        for (int k = 0; k < N; k++)
            order.push_back(rrm[d] ? (mptr[d] + k) % N : N - 1 - k);
        foreach (order[j]) begin
            if (mq[d][order[j]].size() > 0 && n < cdbw[d]) begin
                sel[n] = order[j];
                n++;
            end
        end
    endtask

    task automatic model_edge(input int d);
        int n;
        int sel [2];
        bit [N-1:0] rdy;
        if (flush) begin
            for (int ch = 0; ch < N; ch++) mq[d][ch].delete();
            return;
        end
        model_grants(d, n, sel);
        for (int ch = 0; ch < N; ch++) rdy[ch] = (mq[d][ch].size() < D);
        if (in_cr[d] && n > 0) begin
            for (int s = 0; s < n; s++) void'(mq[d][sel[s]].pop_front());
            mptr[d] = (sel[n-1] + 1) % N;
        end
        for (int ch = 0; ch < N; ch++)
            if (in_valid[d][ch] && rdy[ch]) mq[d][ch].push_back(in_pkt[d][ch]);
    endtask

    task automatic compare(input int d, input string tag);
        int n;
        int sel [2];
        logic [N-1:0]            exp_rdy;
        logic [N-1:0][CNT_W-1:0] exp_cnt;
        model_grants(d, n, sel);
        for (int s = 0; s < cdbw[d]; s++) begin
            check($sformatf("%s.u%0d.valid%0d", tag, d, s), 64'(act_valid[d][s]), 64'(s < n));
            if (s < n) begin
                check($sformatf("%s.u%0d.idx%0d", tag, d, s), 64'(act_idx[d][s]), 64'(sel[s]));
                check($sformatf("%s.u%0d.pkt%0d", tag, d, s), 64'(act_pkt[d][s]),
                      64'(mq[d][sel[s]][0]));
            end else begin
                check($sformatf("%s.u%0d.pkt%0d_zero", tag, d, s), 64'(act_pkt[d][s]), 64'(0));
            end
        end
        for (int ch = 0; ch < N; ch++) begin
            exp_rdy[ch] = (mq[d][ch].size() < D);
            exp_cnt[ch] = CNT_W'(mq[d][ch].size());
        end
        check($sformatf("%s.u%0d.ready", tag, d), 64'(act_ready[d]), 64'(exp_rdy));
        check($sformatf("%s.u%0d.count", tag, d), 64'(act_cnt[d]), 64'(exp_cnt));
    endtask

    task automatic drive(input logic [N-1:0] v, input logic cr, input logic fl);
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = v;
            in_cr[d]    = cr;
            for (int ch = 0; ch < N; ch++) in_pkt[d][ch] = rand_pkt();
        end
        flush = fl;
    endtask

    // Entered at a falling edge with inputs applied; returns at the next falling edge.
    task automatic cycle(input string tag);
        #1;
        compare(0, tag);
        compare(1, tag);
        @(posedge clock);
        model_edge(0);
        model_edge(1);
        @(negedge clock);
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic         a_v;
        int           a_i;
        logic [1:0]   b_v;
        int           b_i0;
        int           b_i1;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{6'b111111, 1'b0, 0, 2'b00, 0, 0};
        vecs[1]  = '{6'b000000, 1'b1, 0, 2'b11, 5, 4};
        vecs[2]  = '{6'b000000, 1'b1, 1, 2'b11, 3, 2};
        vecs[3]  = '{6'b000000, 1'b1, 2, 2'b11, 1, 0};
        vecs[4]  = '{6'b000000, 1'b1, 3, 2'b00, 0, 0};
        vecs[5]  = '{6'b000000, 1'b1, 4, 2'b00, 0, 0};
        vecs[6]  = '{6'b000000, 1'b1, 5, 2'b00, 0, 0};
        vecs[7]  = '{6'b110010, 1'b0, 0, 2'b00, 0, 0};
        vecs[8]  = '{6'b000000, 1'b1, 1, 2'b11, 5, 4};
        vecs[9]  = '{6'b000000, 1'b1, 4, 2'b01, 1, 0};
        vecs[10] = '{6'b000000, 1'b1, 5, 2'b00, 0, 0};
        vecs[11] = '{6'b000000, 1'b0, 0, 2'b00, 0, 0};

        drive('0, 1'b1, 1'b0);
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset.u%0d.valid", d), 64'(act_valid[d]), 64'(0));
            check($sformatf("reset.u%0d.idx", d), 64'(act_idx[d][0]), 64'(0));
            check($sformatf("reset.u%0d.count", d), 64'(act_cnt[d]), 64'(0));
            check($sformatf("reset.u%0d.ready", d), 64'(act_ready[d]), 64'(6'b111111));
        end
        @(negedge clock);
        reset = 1'b1;

        // Round-robin fairness on u0 and fixed dual-slot priority on u1.
        for (int r = 0; r < 12; r++) begin
            drive(vecs[r].valid, 1'b1, 1'b0);
            #1;
            check($sformatf("tbl%0d.a.valid", r), 64'(act_valid[0][0]), 64'(vecs[r].a_v));
            if (vecs[r].a_v) check($sformatf("tbl%0d.a.idx", r), 64'(act_idx[0][0]), 64'(vecs[r].a_i));
            check($sformatf("tbl%0d.b.valid", r), 64'(act_valid[1]), 64'(vecs[r].b_v));
            if (vecs[r].b_v[0]) check($sformatf("tbl%0d.b.idx0", r), 64'(act_idx[1][0]), 64'(vecs[r].b_i0));
            if (vecs[r].b_v[1]) check($sformatf("tbl%0d.b.idx1", r), 64'(act_idx[1][1]), 64'(vecs[r].b_i1));
            cycle($sformatf("tbl%0d", r));
        end

        // One-cycle enqueue-to-grant latency, no bypass.
        drive(6'b001000, 1'b1, 1'b0);
        in_pkt[0][3].dest_value = 32'hA5;
        check("lat.same_cycle_valid", 64'(act_valid[0]), 64'(0));
        cycle("lat0");
        check("lat.valid", 64'(act_valid[0][0]), 64'(1));
        check("lat.idx", 64'(act_idx[0][0]), 64'(3));
        check("lat.value", 64'(act_pkt[0][0].dest_value), 64'(32'hA5));
        drive('0, 1'b1, 1'b0);
        cycle("lat1");
        check("lat.drained", 64'(act_valid[0][0]), 64'(0));

        // Backpressure fills channel 0, then a single pop reopens it.
        drive(6'b000001, 1'b0, 1'b0);
        cycle("bp0");
        drive(6'b000001, 1'b0, 1'b0);
        cycle("bp1");
        check("bp.ready_low", 64'(act_ready[0][0]), 64'(0));
        check("bp.count2", 64'(act_cnt[0][0]), 64'(2));
        check("bp.still_shown", 64'(act_valid[0][0]), 64'(1));
        drive('0, 1'b1, 1'b0);
        cycle("bp2");
        check("bp.count1", 64'(act_cnt[0][0]), 64'(1));
        check("bp.ready_high", 64'(act_ready[0][0]), 64'(1));
        cycle("bp3");

        // Flush squashes buffered results and ignores same-cycle pushes.
        drive(6'b010101, 1'b0, 1'b0);
        cycle("fl0");
        drive(6'b000010, 1'b1, 1'b1);
        cycle("fl1");
        drive('0, 1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("fl.u%0d.count", d), 64'(act_cnt[d]), 64'(0));
            check($sformatf("fl.u%0d.valid", d), 64'(act_valid[d]), 64'(0));
        end
        cycle("fl2");
        check("fl.no_grant", 64'(act_valid[0]), 64'(0));

        // Asynchronous reset in the middle of a fill.
        drive(6'b000100, 1'b0, 1'b0);
        cycle("rs0");
        drive(6'b000100, 1'b0, 1'b0);
        cycle("rs1");
        check("rs.count2", 64'(act_cnt[0][2]), 64'(2));
        drive('0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rs.valid_now", 64'(act_valid[0]), 64'(0));
        check("rs.count_now", 64'(act_cnt[0]), 64'(0));
        check("rs.count_now_b", 64'(act_cnt[1]), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rs.ready_after", 64'(act_ready[0]), 64'(6'b111111));
        @(negedge clock);

        // Randomized traffic; pushes only offered where the model says there is room.
        for (int c = 0; c < 600; c++) begin
            drive('0, 1'b0, ($urandom_range(0, 29) == 0));
            for (int d = 0; d < 2; d++) begin
                logic [N-1:0] rdy;
                for (int ch = 0; ch < N; ch++) rdy[ch] = (mq[d][ch].size() < D);
                in_valid[d] = N'($urandom) & rdy;
                in_cr[d]    = ($urandom_range(0, 3) != 0);
            end
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
